linear_feedback_shift_register: RTL and testbench
=================================================

// Module: linear_feedback_shift_register
//
// PURPOSE
// - Serial pseudo-random bit generator built on a WIDTH-bit Fibonacci LFSR. Default polynomial is
//   maximal-length: x^32+x^22+x^2+x+1.
// - The state can be seeded synchronously, and the MSB of the state is emitted one bit per clock.
// - Used as a test-pattern / noise source. Single clock domain, no handshake.
//
// PARAMETERS
// - WIDTH         32             state/seed width, >= 2
// - TAPS          32'h8020_0003  feedback mask; bit i set => state[i] XORed into feedback
// - DEFAULT_SEED  32'h0000_0001  state after reset and replacement for an all-zero seed; must be nonzero
//
// PORTS (positional order is fixed: q, clock, rst, seed, load)
// - q      output  1      serial output = state[WIDTH-1], driven straight from the state register
// - clock  input   1      rising-edge clock
// - rst    input   1      reset, asynchronous, active-high
// - seed   input   WIDTH  value loaded into the state when load=1
// - load   input   1      synchronous seed-load strobe
//
// BEHAVIOUR
// - Clock and reset: one clock, clock. Reset rst is asynchronous and active-high.
// - Reset:
//   - While rst=1, state is forced to DEFAULT_SEED immediately, with no clock edge needed.
//   - q follows DEFAULT_SEED[WIDTH-1], which is 0 for the default value.
//   - rst overrides load and shifting. Deasserting rst mid-run restarts from DEFAULT_SEED.
// - Per rising edge of clock when rst=0, priority order:
//   1. load=1:
//      - state <= seed, but state <= DEFAULT_SEED if seed==0 (lock-up guard).
//      - No shift happens this cycle.
//   2. Otherwise:
//      - fb = ^(state & TAPS).
//      - state <= {state[WIDTH-2:0], fb}, i.e. shift toward the MSB and insert fb at bit 0.
// - Latency:
//   - q reflects the loaded seed's MSB one edge after load is sampled.
//   - Each following edge presents the next bit. There is no combinational path from inputs to q.
// - Holding load=1 over several edges reloads seed every edge; q stays at seed[WIDTH-1].
// - seed is sampled only on edges where load=1; at other times it is don't-care.
// - The all-zero state can never be entered:
//   - Reset gives DEFAULT_SEED.
//   - A zero load is replaced by DEFAULT_SEED.
//   - A nonzero state under a maximal polynomial never reaches zero.
// - Period with the default TAPS is 2^32-1 cycles from any nonzero state.
// - X on load or seed during reset is ignored.
//
// TESTING
// - Reset: pulse rst high for 10 ns between clock edges
//   -> state = 32'h0000_0001 asynchronously; q = 0.
// - Load then free run: seed = 32'h150F_2464, load = 1 for one edge, then 0
//   -> state after load = 150F_2464 (q=0).
//   -> Following edges: 2A1E_48C8 (q=0), 543C_9190 (q=0), A879_2321 (q=1).
// - Zero seed: load = 1 with seed = 0 -> state = 32'h0000_0001; the sequence then advances normally.
// - Load held: load = 1 for 3 edges with seed = 32'h8000_0000
//   -> state is 8000_0000 each time; q stays 1.
// - Async reset mid-run: assert rst between edges after 5 shifts
//   -> state = 0000_0001 before the next edge.
//   -> After release, shifting resumes: 0000_0003, 0000_0006, ...
// - Period and lock-up: a reduced-WIDTH build (WIDTH=4, TAPS=4'b1001, DEFAULT_SEED=1)
//   -> returns to 4'h1 after exactly 15 shifts and never reaches 4'h0.

Source files
------------

// File: rtl/linear_feedback_shift_register.sv
// -----------------------------------------------------------------------------
// linear_feedback_shift_register
//
// Serial pseudo-random bit generator built on a WIDTH-bit Fibonacci LFSR.
// The default feedback polynomial x^32+x^22+x^2+x+1 is maximal-length.
// The state can be seeded synchronously. The MSB of the state is emitted one
// bit per clock, straight from the state register.
//
// Ports
//   q      out  1      serial output, state[WIDTH-1]
//   clock  in   1      rising-edge clock
//   rst    in   1      asynchronous, active-high reset; state <= DEFAULT_SEED
//   seed   in   WIDTH  value loaded when load=1 (zero is replaced by DEFAULT_SEED)
//   load   in   1      synchronous seed-load strobe; has priority over shifting
// -----------------------------------------------------------------------------
module linear_feedback_shift_register #(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] TAPS         = 32'h8020_0003,
  parameter logic [WIDTH-1:0] DEFAULT_SEED = 32'h0000_0001
) (
  output logic             q,
  input  logic             clock,
  input  logic             rst,
  input  logic [WIDTH-1:0] seed,
  input  logic             load
);

  logic [WIDTH-1:0] state;
  logic [WIDTH-1:0] next_state;

  // An all-zero state would lock the register up, so a zero seed is swapped
  // for the default seed.
  function automatic logic [WIDTH-1:0] guard_seed(input logic [WIDTH-1:0] s);
    guard_seed = (s == '0) ? DEFAULT_SEED : s;
  endfunction

  // Fibonacci step: parity of the tapped bits enters at bit 0 while the
  // register shifts toward the MSB.
  function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] s);
    logic fb;
    fb        = ^(s & TAPS);
    lfsr_step = {s[WIDTH-2:0], fb};
  endfunction

  always_comb begin
    next_state = lfsr_step(state);
    if (load) begin
      next_state = guard_seed(seed);
    end
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state <= DEFAULT_SEED;
    end else begin
      state <= next_state;
    end
  end

  assign q = state[WIDTH-1];

endmodule

// File: tb/tb_linear_feedback_shift_register.sv
// -----------------------------------------------------------------------------
// Testbench for linear_feedback_shift_register: a 32-bit default build driven
// by a vector table, hand-written reset sequences and a random load/shift run
// scored against a queue, plus a WIDTH=4 build used for the period check.
// -----------------------------------------------------------------------------
module tb_linear_feedback_shift_register;

  logic        clock = 1'b0;
  logic        rst   = 1'b0;
  logic        load  = 1'b0;
  logic [31:0] seed  = 32'h0;
  logic        q;

  logic        rst4  = 1'b0;
  logic        load4 = 1'b0;
  logic [3:0]  seed4 = 4'h0;
  logic        q4;

  always #10 clock = ~clock;

  linear_feedback_shift_register dut (
    .q     (q),
    .clock (clock),
    .rst   (rst),
    .seed  (seed),
    .load  (load)
  );

  linear_feedback_shift_register #(
    .WIDTH        (4),
    .TAPS         (4'b1001),
    .DEFAULT_SEED (4'h1)
  ) dut4 (
    .q     (q4),
    .clock (clock),
    .rst   (rst4),
    .seed  (seed4),
    .load  (load4)
  );

  typedef struct {
    logic        ld;
    logic [31:0] sd;
    logic [31:0] exp_state;
  } vec_t;

  vec_t        vecs[11];
  logic [31:0] sb[$];
  logic [31:0] mstate;
  int          tests = 0;
  int          fails = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Reference next-state for the default 32-bit build.
  function automatic logic [31:0] model_next(input logic [31:0] cur, input logic ld,
                                             input logic [31:0] sd);
    logic fb;
    if (ld) return (sd == 32'h0) ? 32'h0000_0001 : sd;
    fb = cur[31] ^ cur[21] ^ cur[1] ^ cur[0];
    return {cur[30:0], fb};
  endfunction

  // Drive one edge's inputs, queue the expectation, then compare just after the edge.
  task automatic drive(input string name, input logic ld, input logic [31:0] sd,
                       input logic [31:0] exp);
    logic [31:0] e;
    load = ld;
    seed = sd;
    sb.push_back(exp);
    @(posedge clock);
    #1;
    e = sb.pop_front();
    check32({name, "_state"}, dut.state, e);
    check1({name, "_q"}, q, e[31]);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] m4;
    logic       ld;
    logic [31:0] sd;

    vecs[0]  = '{1'b1, 32'h150F_2464, 32'h150F_2464};
    vecs[1]  = '{1'b0, 32'h0,         32'h2A1E_48C8};
    vecs[2]  = '{1'b0, 32'h0,         32'h543C_9190};
    vecs[3]  = '{1'b0, 32'h0,         32'hA879_2321};
    vecs[4]  = '{1'b1, 32'h0,         32'h0000_0001};
    vecs[5]  = '{1'b0, 32'h0,         32'h0000_0003};
    vecs[6]  = '{1'b0, 32'h0,         32'h0000_0006};
    vecs[7]  = '{1'b1, 32'h8000_0000, 32'h8000_0000};
    vecs[8]  = '{1'b1, 32'h8000_0000, 32'h8000_0000};
    vecs[9]  = '{1'b1, 32'h8000_0000, 32'h8000_0000};
    vecs[10] = '{1'b0, 32'h0,         32'h0000_0001};

    // Asynchronous reset before any clock edge.
    #2;
    rst  = 1'b1;
    rst4 = 1'b1;
    #2;
    check32("reset_async_state", dut.state, 32'h0000_0001);
    check1("reset_async_q", q, 1'b0);
    check32("reset_async_state4", {28'h0, dut4.state}, 32'h1);

    // Reset overrides a load across an edge.
    load = 1'b1;
    seed = 32'hFFFF_FFFF;
    @(posedge clock);
    #1;
    check32("reset_over_load", dut.state, 32'h0000_0001);
    load = 1'b0;
    seed = 32'h0;
    #1;
    rst4 = 1'b0;

    // Reduced-width build: period 15, never zero.
    m4 = 4'h1;
    for (int i = 1; i <= 15; i++) begin
      @(posedge clock);
      #1;
      m4 = {m4[2:0], m4[3] ^ m4[0]};
      check32($sformatf("w4_step%0d", i), {28'h0, dut4.state}, {28'h0, m4});
      check1($sformatf("w4_nonzero%0d", i), (dut4.state == 4'h0), 1'b0);
      check1($sformatf("w4_q%0d", i), q4, m4[3]);
    end
    check32("w4_period", {28'h0, dut4.state}, 32'h1);
    rst = 1'b0;

    // Table-driven vectors.
    for (int i = 0; i < 11; i++) begin
      drive($sformatf("vec%0d", i), vecs[i].ld, vecs[i].sd, vecs[i].exp_state);
    end

    // Reset mid-run after five shifts.
    mstate = model_next(32'h0, 1'b1, 32'hDEAD_BEEF);
    drive("mid_load", 1'b1, 32'hDEAD_BEEF, mstate);
    for (int i = 0; i < 5; i++) begin
      mstate = model_next(mstate, 1'b0, 32'h0);
      drive($sformatf("mid_shift%0d", i), 1'b0, 32'h0, mstate);
    end
    #2;
    rst = 1'b1;
    #2;
    check32("mid_reset_state", dut.state, 32'h0000_0001);
    check1("mid_reset_q", q, 1'b0);
    #8;
    rst = 1'b0;
    drive("resume0", 1'b0, 32'h0, 32'h0000_0003);
    drive("resume1", 1'b0, 32'h0, 32'h0000_0006);
    drive("resume2", 1'b0, 32'h0, 32'h0000_000D);

    // Random loads and shifts, scored against the model.
    mstate = 32'h0000_000D;
    for (int i = 0; i < 60; i++) begin
      ld = ($urandom_range(0, 3) == 0);
      sd = ($urandom_range(0, 4) == 0) ? 32'h0 : $urandom;
      mstate = model_next(mstate, ld, sd);
      drive($sformatf("rand%0d", i), ld, sd, mstate);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
